ram_bist_checker: RTL
=====================

Name: ram_bist_checker

Overview:
- Synthesizable, parametrised self-checking traffic engine for dp_ram. Writes a burst through port A, then reads it back through port B and compares.
- Successor to the single-word write/stall/read/check bench loop. Adds burst depth, address scrambling, per-run seeding, read-ack timeout and error statistics.
- Sits beside any dp_ram instance and drives its A-write and B-read ports. Usable in simulation and on silicon as a memory BIST.

Parameters:
- DATA_WIDTH, 32, RAM word width in bits.
- RAM_DEPTH, 512, words in the target RAM (power of two).
- BURST_LEN, 64, words per run (1..RAM_DEPTH).
- MAX_STALL, 7, maximum idle cycles inserted after each write.
- ACK_TIMEOUT, 15, maximum cycles to wait for rdAckBIn after rdEnBOut.
- Derived: ADDR_WIDTH=$clog2(RAM_DEPTH), STALL_WIDTH=$clog2(MAX_STALL+1), WREN_WIDTH=(DATA_WIDTH+7)/8.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- startIn  in  1  starts a run; sampled only in IDLE.
- scrambleIn  in  1  address mode, latched at start: 0 = linear, 1 = bit-reversed.
- seedIn  in  32  LFSR seed, latched at start; 0 is replaced by 32'h1.
- addrAOut  out  ADDR_WIDTH  port A address.
- wrEnAOut  out  WREN_WIDTH  port A byte write enables.
- wrDataAOut  out  DATA_WIDTH  port A write data.
- addrBOut  out  ADDR_WIDTH  port B address.
- rdEnBOut  out  1  port B read request.
- rdDataBIn  in  DATA_WIDTH  port B read data.
- rdAckBIn  in  1  port B read-data valid.
- busyOut  out  1  high from the start cycle until DONE.
- doneOut  out  1  one-cycle pulse at end of run.
- passOut  out  1  high when the last run had no errors and no timeout; held until the next start.
- errCountOut  out  16  miscompare count, saturating at 16'hFFFF.
- firstErrAddrOut  out  ADDR_WIDTH  address of the first miscompare.
- timeoutOut  out  1  set if a read ack timed out; held until the next start.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, LFSR = 1.
- States: IDLE, WRITE, STALL, READ, WAIT, DONE.
- IDLE:
  - On startIn, latch seed and mode, clear counters, passOut, timeoutOut and firstErrAddrOut, then go to WRITE.
  - busyOut rises in the same cycle startIn is sampled.
- WRITE:
  - One cycle per word.
  - Drive wrEnAOut all ones, wrDataAOut = data(LFSR), addrAOut = map(idx).
  - Advance the LFSR.
  - stall = LFSR[STALL_WIDTH-1:0], clipped to MAX_STALL. If stall = 0, go to the next WRITE; otherwise go to STALL.
  - After word BURST_LEN-1: reload the LFSR with the latched seed, set idx to 0, and go to READ without stalling.
- STALL: decrement the stall count; return to WRITE when the count equals 1. wrEnAOut is 0 in STALL.
- READ:
  - One-cycle rdEnBOut pulse with addrBOut = map(idx), then go to WAIT.
  - Only one read is outstanding at a time.
- WAIT, on rdAckBIn:
  - Compare rdDataBIn with data(LFSR) and advance the LFSR.
  - On mismatch: errCount += 1 (saturating). On the first mismatch, capture addrBOut into firstErrAddrOut.
  - Next state: READ, or DONE after the last index.
- WAIT timeout:
  - If no ack arrives within ACK_TIMEOUT cycles, set timeoutOut and go to DONE.
  - A late ack is ignored.
- DONE:
  - Assert doneOut for one cycle.
  - passOut = (errCount == 0) && !timeoutOut.
  - Drop busyOut, return to IDLE.
- LFSR: 32-bit Galois, taps x^32+x^22+x^2+x+1.
- data(LFSR): the 32-bit value replicated and truncated to DATA_WIDTH.
- map(idx):
  - Linear mode: idx.
  - Scrambled mode: bit-reverse of idx over ADDR_WIDTH bits. This is bijective, so no overwrite aliasing occurs.
  - idx wraps modulo RAM_DEPTH.
- Edge cases:
  - startIn while busy is ignored.
  - rdAckBIn outside WAIT is ignored.
  - rst mid-run aborts immediately to reset values; no doneOut is issued.
- Run latency with zero stalls and a 1-cycle ack: 1 + BURST_LEN + 3·BURST_LEN cycles (IDLE, WRITE, READ/WAIT/ack) + 1 (DONE), ±1 depending on RAM read latency.

Decomposition:
- Package bist_pkg holds:
  - state encoding constants;
  - LFSR polynomial and default seed;
  - a function for the LFSR next value;
  - a function for bit-reverse.
- One sub-module, bist_lfsr (load, advance, value), instantiated once.
- The FSM and comparator live in the top module.

Test Plan:
- Seed 32'hACE1, linear mode, BURST_LEN=8, dp_ram attached, start pulse -> 8 writes to addresses 0..7, 8 reads, doneOut pulse, passOut=1, errCountOut=0.
- Scrambled mode, RAM_DEPTH=512 -> write addresses in order 0, 256, 128, 384…; pass=1.
- Bench flips bit 0 of rdDataBIn on the 3rd ack -> errCountOut=1, firstErrAddrOut=2 (linear), passOut=0.
- Bench withholds rdAckBIn on the 5th read -> timeoutOut=1 after 15 cycles, doneOut pulse, passOut=0; a late ack is ignored.
- rst asserted during STALL, then a new start with seedIn=0 -> clean restart, all outputs 0 on the reset cycle, LFSR seeded with 1, pass=1.
- startIn held high throughout the run -> no second start until after DONE. Check the maximum stall: no STALL run exceeds MAX_STALL=7 cycles.

Source files
------------

// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared types, LFSR and address helpers for the RAM BIST checker
//
// Contents:
//   bistState_t        FSM state encoding
//   LFSR_POLY          Galois tap mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
//   LFSR_DEFAULT_SEED  reset value, also used in place of a zero seed
//   lfsrNext()         one LFSR step
//   bitReverse()       reverse the low 'width' bits of a word
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_STALL,
        ST_READ,
        ST_WAIT,
        ST_DONE
    } bistState_t;

    localparam logic [31:0] LFSR_POLY         = 32'h8020_0003;
    localparam logic [31:0] LFSR_DEFAULT_SEED = 32'h0000_0001;

    function automatic logic [31:0] lfsrNext(input logic [31:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_POLY) : (cur >> 1);
    endfunction

    // Reverse all 32 bits, then shift the reversed field down so that only
    // the low 'width' bits of the input end up reversed in the low bits.
    function automatic logic [31:0] bitReverse(input logic [31:0] v, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r >> (32 - width);
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// rtl/bist_lfsr.sv - 32-bit Galois LFSR with load and advance controls
//
// Ports:
//   clk, rst       clock, synchronous active-high reset (value returns to 1)
//   load           load seedIn (takes priority over advance)
//   advance        step the LFSR once
//   seedIn [31:0]  value to load
//   valueOut[31:0] current LFSR state
module bist_lfsr
    import bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    input  logic [31:0] seedIn,
    output logic [31:0] valueOut
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valueOut <= LFSR_DEFAULT_SEED;
        end else if (load) begin
            valueOut <= seedIn;
        end else if (advance) begin
            valueOut <= lfsrNext(valueOut);
        end
    end

endmodule

// File: rtl/ram_bist_checker.sv
// rtl/ram_bist_checker.sv - burst write / read-back / compare traffic engine for dp_ram
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   startIn, scrambleIn, seedIn  run control, latched when a run starts in IDLE
//   addrAOut, wrEnAOut, wrDataAOut  dp_ram port A write side
//   addrBOut, rdEnBOut           dp_ram port B read request
//   rdDataBIn, rdAckBIn          dp_ram port B read data and its valid
//   busyOut, doneOut             run in progress / one-cycle end-of-run pulse
//   passOut, timeoutOut          last run result, held until the next start
//   errCountOut, firstErrAddrOut miscompare statistics
//
// All outputs are registered: a bus action decided in a state becomes
// visible on the ports during the following cycle.
module ram_bist_checker
    import bist_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int RAM_DEPTH   = 512,
    parameter int BURST_LEN   = 64,
    parameter int MAX_STALL   = 7,
    parameter int ACK_TIMEOUT = 15,
    localparam int ADDR_WIDTH  = $clog2(RAM_DEPTH),
    localparam int STALL_WIDTH = $clog2(MAX_STALL + 1),
    localparam int WREN_WIDTH  = (DATA_WIDTH + 7) / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  startIn,
    input  logic                  scrambleIn,
    input  logic [31:0]           seedIn,
    output logic [ADDR_WIDTH-1:0] addrAOut,
    output logic [WREN_WIDTH-1:0] wrEnAOut,
    output logic [DATA_WIDTH-1:0] wrDataAOut,
    output logic [ADDR_WIDTH-1:0] addrBOut,
    output logic                  rdEnBOut,
    input  logic [DATA_WIDTH-1:0] rdDataBIn,
    input  logic                  rdAckBIn,
    output logic                  busyOut,
    output logic                  doneOut,
    output logic                  passOut,
    output logic [15:0]           errCountOut,
    output logic [ADDR_WIDTH-1:0] firstErrAddrOut,
    output logic                  timeoutOut
);

    localparam int CNT_WIDTH = $clog2(BURST_LEN + 1);
    localparam int TO_WIDTH  = $clog2(ACK_TIMEOUT + 1);

    bistState_t             state;
    logic [31:0]            seedLatched;
    logic                   scrambleLatched;
    logic [ADDR_WIDTH-1:0]  idx;
    logic [CNT_WIDTH-1:0]   wordCnt;
    logic [STALL_WIDTH-1:0] stallCnt;
    logic [TO_WIDTH-1:0]    waitCnt;

    logic                   lfsrLoad;
    logic                   lfsrAdvance;
    logic [31:0]            lfsrSeed;
    logic [31:0]            lfsrValue;

    logic [31:0]            seedFixed;
    logic [ADDR_WIDTH-1:0]  mapIdx;
    logic [DATA_WIDTH-1:0]  lfsrData;
    logic [STALL_WIDTH-1:0] stallRaw;
    logic [STALL_WIDTH-1:0] stallClip;
    logic                   lastWord;

    bist_lfsr uLfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (lfsrLoad),
        .advance  (lfsrAdvance),
        .seedIn   (lfsrSeed),
        .valueOut (lfsrValue)
    );

    assign seedFixed = (seedIn == 32'h0) ? LFSR_DEFAULT_SEED : seedIn;
    assign mapIdx    = scrambleLatched ? ADDR_WIDTH'(bitReverse(32'(idx), ADDR_WIDTH)) : idx;
    assign lastWord  = (wordCnt == CNT_WIDTH'(BURST_LEN - 1));

    // The stall length comes from the LFSR value that follows the word
    // just written, i.e. the state after this cycle's advance.
    assign stallRaw  = STALL_WIDTH'(lfsrNext(lfsrValue));
    assign stallClip = (stallRaw > STALL_WIDTH'(MAX_STALL)) ? STALL_WIDTH'(MAX_STALL) : stallRaw;

    always_comb begin
        lfsrData = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            lfsrData[i] = lfsrValue[i % 32];
        end
    end

    // The LFSR is seeded at start, re-seeded after the last write so the
    // read phase regenerates the same data sequence, and advanced once per
    // word written and once per ack compared.
    always_comb begin
        lfsrLoad    = 1'b0;
        lfsrAdvance = 1'b0;
        lfsrSeed    = seedLatched;
        case (state)
            ST_IDLE: begin
                lfsrLoad = startIn;
                lfsrSeed = seedFixed;
            end
            ST_WRITE: begin
                lfsrLoad    = lastWord;
                lfsrAdvance = 1'b1;
            end
            ST_WAIT: begin
                lfsrAdvance = rdAckBIn;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            seedLatched     <= '0;
            scrambleLatched <= 1'b0;
            idx             <= '0;
            wordCnt         <= '0;
            stallCnt        <= '0;
            waitCnt         <= '0;
            addrAOut        <= '0;
            wrEnAOut        <= '0;
            wrDataAOut      <= '0;
            addrBOut        <= '0;
            rdEnBOut        <= 1'b0;
            busyOut         <= 1'b0;
            doneOut         <= 1'b0;
            passOut         <= 1'b0;
            errCountOut     <= '0;
            firstErrAddrOut <= '0;
            timeoutOut      <= 1'b0;
        end else begin
            doneOut  <= 1'b0;
            wrEnAOut <= '0;
            rdEnBOut <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (startIn) begin
                        seedLatched     <= seedFixed;
                        scrambleLatched <= scrambleIn;
                        idx             <= '0;
                        wordCnt         <= '0;
                        errCountOut     <= '0;
                        firstErrAddrOut <= '0;
                        passOut         <= 1'b0;
                        timeoutOut      <= 1'b0;
                        busyOut         <= 1'b1;
                        state           <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    wrEnAOut   <= '1;
                    wrDataAOut <= lfsrData;
                    addrAOut   <= mapIdx;
                    if (lastWord) begin
                        idx     <= '0;
                        wordCnt <= '0;
                        state   <= ST_READ;
                    end else begin
                        idx     <= idx + ADDR_WIDTH'(1);
                        wordCnt <= wordCnt + CNT_WIDTH'(1);
                        if (stallClip != '0) begin
                            stallCnt <= stallClip;
                            state    <= ST_STALL;
                        end
                    end
                end
                ST_STALL: begin
                    stallCnt <= stallCnt - STALL_WIDTH'(1);
                    if (stallCnt == STALL_WIDTH'(1)) begin
                        state <= ST_WRITE;
                    end
                end
                ST_READ: begin
                    rdEnBOut <= 1'b1;
                    addrBOut <= mapIdx;
                    waitCnt  <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (rdAckBIn) begin
                        if (rdDataBIn != lfsrData) begin
                            if (errCountOut != 16'hFFFF) begin
                                errCountOut <= errCountOut + 16'd1;
                            end
                            if (errCountOut == 16'd0) begin
                                firstErrAddrOut <= addrBOut;
                            end
                        end
                        if (lastWord) begin
                            state <= ST_DONE;
                        end else begin
                            idx     <= idx + ADDR_WIDTH'(1);
                            wordCnt <= wordCnt + CNT_WIDTH'(1);
                            state   <= ST_READ;
                        end
                    end else if (waitCnt == TO_WIDTH'(ACK_TIMEOUT - 1)) begin
                        timeoutOut <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        waitCnt <= waitCnt + TO_WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    doneOut <= 1'b1;
                    passOut <= (errCountOut == 16'd0) && !timeoutOut;
                    busyOut <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
